sarlock_adder_seq: RTL and testbench

Parametrised, pipelined W-bit adder protected by SARLock point-function locking. The key is loaded serially through a valid/ready bit-shift port, and operands and results flow through valid/ready handshakes. While the loaded key differs from `CORRECT_KEY`, exactly one operand pair per key (`{b,a} == key`) returns a corrupted sum. The block is the sequential, width-generic successor of the combinational locked adder and sits between the operand source and the result consumer in locked-datapath benchmarks.

---
 rtl/sarlock_adder_seq.sv | 136 +++++++++++++
 tb/tb_sarlock_adder_seq.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sarlock_adder_seq.sv
// sarlock_adder_seq: W-bit valid/ready adder protected by SARLock point-function locking.
// A 2W-bit key is shifted in MSB first. While it differs from CORRECT_KEY, the single
// operand pair with {b,a} == key returns its sum XORed with FLIP_MASK.
// Optional feature macro: SARLOCK_PIPE_EN selects a two-stage datapath (latency 2);
// when undefined the datapath is a single output register (latency 1).
module sarlock_adder_seq #(
    parameter int             W           = 4,
    parameter logic [2*W-1:0] CORRECT_KEY = 'h5A,
    parameter logic [W:0]     FLIP_MASK   = 'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_bit,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic         key_clear,
    output logic         key_loaded,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W:0]   sum
);

    localparam int KW = 2 * W;
    localparam int CW = $clog2(KW + 1);

    typedef enum logic [1:0] {
        EMPTY,
        SHIFT,
        ARMED
    } key_state_t;

    key_state_t    state;
    key_state_t    state_next;
    logic [KW-1:0] key_sr;
    logic [KW-1:0] key_sr_next;
    logic [CW-1:0] bit_cnt;
    logic [CW-1:0] bit_cnt_next;
    logic          key_accept;

    logic          advance;
    logic          accept;
    logic          fire;
    logic [W:0]    raw;

    // Key state, shift register and bit counter; reset drops any partial key.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= EMPTY;
            key_sr  <= '0;
            bit_cnt <= '0;
        end else begin
            state   <= state_next;
            key_sr  <= key_sr_next;
            bit_cnt <= bit_cnt_next;
        end
    end

    // Key loader: clear beats a simultaneous key bit, the 2W-th accepted bit arms the lock.
    always_comb begin
        state_next   = state;
        key_sr_next  = key_sr;
        bit_cnt_next = bit_cnt;
        key_ready    = (state != ARMED);
        key_loaded   = (state == ARMED);
        key_accept   = key_valid && key_ready;
        if (key_clear) begin
            state_next   = EMPTY;
            key_sr_next  = '0;
            bit_cnt_next = '0;
        end else if (key_accept) begin
            key_sr_next = {key_sr[KW-2:0], key_bit};
            if (state == EMPTY) begin
                bit_cnt_next = CW'(1);
                state_next   = SHIFT;
            end else begin
                bit_cnt_next = bit_cnt + CW'(1);
                if (bit_cnt == CW'(KW - 1)) begin
                    state_next = ARMED;
                end
            end
        end
    end

    // The whole datapath moves only when the output register is free or being drained.
    assign advance  = !out_valid || out_ready;
    assign in_ready = (state == ARMED) && advance;
    assign accept   = in_valid && in_ready;
    assign raw      = {1'b0, a} + {1'b0, b};
    assign fire     = ({b, a} == key_sr) && ({b, a} != CORRECT_KEY);

`ifdef SARLOCK_PIPE_EN
    logic       s1_valid;
    logic       s1_fire;
    logic [W:0] s1_raw;

    // Stage 1 captures raw sum and lock decision with the key seen at acceptance;
    // stage 2 applies the flip. Both stall together so stage 1 never overruns stage 2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_fire   <= 1'b0;
            s1_raw    <= '0;
            out_valid <= 1'b0;
            sum       <= '0;
        end else if (advance) begin
            s1_valid <= accept;
            if (accept) begin
                s1_raw  <= raw;
                s1_fire <= fire;
            end
            out_valid <= s1_valid;
            if (s1_valid) begin
                sum <= s1_raw ^ (s1_fire ? FLIP_MASK : '0);
            end
        end
    end
`else
    // Single output register: load on acceptance, hold under backpressure, clear once drained.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            sum       <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            sum       <= raw ^ (fire ? FLIP_MASK : '0);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_sarlock_adder_seq.sv
// tb_sarlock_adder_seq: scoreboard bench for sarlock_adder_seq (W=4, key 8'h5A, mask 5'b00001).
// Expected sums are pushed when an operand pair is accepted; a monitor pops and compares
// each result the DUT hands over.
module tb_sarlock_adder_seq;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         key_bit;
    logic         key_valid;
    logic         key_ready;
    logic         key_clear;
    logic         key_loaded;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W:0]   sum;

    int         errors = 0;
    int         checks = 0;
    logic [W:0] exp_q[$];
    int         cycle = 0;
    int         pop_count = 0;
    int         sweep_mark = -1;
    int         first_sweep_pop = 0;
    int         last_pop = 0;
    int         issue_start = 0;
    int         issue_cycles = 0;
    bit         bad;

    sarlock_adder_seq #(
        .W          (W),
        .CORRECT_KEY(8'h5A),
        .FLIP_MASK  (5'b00001)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_bit   (key_bit),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_clear (key_clear),
        .key_loaded(key_loaded),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum)
    );

    // Free-running clock and cycle counter.
    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // Monitor: every handed-over result is compared with the oldest expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            pop_count++;
            if (pop_count == sweep_mark + 1) first_sweep_pop = cycle;
            last_pop = cycle;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_result actual=%0h required=none", sum);
            end else begin
                checkOutput("result", sum, exp_q.pop_front());
            end
        end
    end

    // Present one operand pair and record its expected sum at the accepting edge.
    task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic [W:0] expv);
        bit done = 1'b0;
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(expv);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout actual=in_ready_low required=accept");
        end
    endtask

    // Shift the top n bits of k MSB first; flag if the key arms early or stalls.
    task automatic shiftBits(input logic [7:0] k, input int n, output bit flag);
        flag = 1'b0;
        for (int i = 0; i < n; i++) begin
            key_bit   = k[7-i];
            key_valid = 1'b1;
            @(negedge clk);
            if (key_loaded || !key_ready) flag = 1'b1;
            @(posedge clk);
            #1;
        end
        key_valid = 1'b0;
    endtask

    // Wait (bounded) until all expected results have been seen, then resync after an edge.
    task automatic drainResults();
        bit done = 1'b0;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0) done = 1'b1;
        end
        checkOutput("drain", 32'(done), 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Watchdog so the bench always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        key_bit   = 1'b0;
        key_valid = 1'b0;
        key_clear = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_key_ready", 32'(key_ready), 32'd1);
        checkOutput("reset_key_loaded", 32'(key_loaded), 32'd0);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_sum", 32'(sum), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // No key: operands must be refused
        a        = 4'h3;
        b        = 4'h2;
        in_valid = 1'b1;
        bad      = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (in_ready || out_valid || key_loaded || !key_ready || sum !== 5'h00) bad = 1'b1;
        end
        checkOutput("nokey_hold", 32'(bad), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;

        // Correct key and full sweep at one result per cycle
        shiftBits(8'h5A, 8, bad);
        checkOutput("load5A_early", 32'(bad), 32'd0);
        checkOutput("load5A_loaded", 32'(key_loaded), 32'd1);
        checkOutput("load5A_key_ready", 32'(key_ready), 32'd0);
        sweep_mark  = pop_count;
        issue_start = cycle;
        for (int i = 0; i < 256; i++) begin
            logic [7:0] p;
            p = 8'(i);
            applyStimulus(p[3:0], p[7:4], {1'b0, p[3:0]} + {1'b0, p[7:4]});
        end
        issue_cycles = cycle - issue_start;
        in_valid = 1'b0;
        drainResults();
        checkOutput("sweep_issue_cycles", 32'(issue_cycles), 32'd256);
        checkOutput("sweep_results", 32'(pop_count - sweep_mark), 32'd256);
        checkOutput("sweep_span", 32'(last_pop - first_sweep_pop), 32'd255);

        // Wrong key 8'h37: only {b,a}=8'h37 is corrupted
        key_clear = 1'b1;
        @(posedge clk);
        #1;
        key_clear = 1'b0;
        checkOutput("clear_key_loaded", 32'(key_loaded), 32'd0);
        checkOutput("clear_key_ready", 32'(key_ready), 32'd1);
        shiftBits(8'h37, 8, bad);
        checkOutput("load37_early", 32'(bad), 32'd0);
        checkOutput("load37_loaded", 32'(key_loaded), 32'd1);
        applyStimulus(4'h7, 4'h3, 5'h0B);
        applyStimulus(4'h7, 4'h4, 5'h0B);
        applyStimulus(4'hF, 4'hF, 5'h1E);
        in_valid = 1'b0;
        drainResults();

        // Backpressure: result holds and input is refused
        out_ready = 1'b0;
        applyStimulus(4'h7, 4'h3, 5'h0B);
        in_valid = 1'b0;
        bad = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (out_valid) begin
                bad = 1'b0;
                break;
            end
        end
        checkOutput("bp_out_valid", 32'(bad), 32'd0);
        a        = 4'h1;
        b        = 4'h1;
        in_valid = 1'b1;
        repeat (4) begin
            checkOutput("bp_sum_hold", 32'(sum), 32'h0B);
            checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
            checkOutput("bp_out_valid_hold", 32'(out_valid), 32'd1);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        applyStimulus(4'h1, 4'h1, 5'h02);
        in_valid = 1'b0;
        drainResults();

        // Clear on the accepting edge: in-flight result keeps the old key's flip
        a         = 4'h7;
        b         = 4'h3;
        in_valid  = 1'b1;
        key_clear = 1'b1;
        key_bit   = 1'b1;
        key_valid = 1'b1;
        @(negedge clk);
        checkOutput("clr_in_ready", 32'(in_ready), 32'd1);
        if (in_ready) exp_q.push_back(5'h0B);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        key_clear = 1'b0;
        key_valid = 1'b0;
        checkOutput("clr_key_loaded", 32'(key_loaded), 32'd0);
        checkOutput("clr_key_ready", 32'(key_ready), 32'd1);
        drainResults();

        // Clear beats a simultaneous key bit while shifting
        shiftBits(8'hFF, 3, bad);
        key_clear = 1'b1;
        key_bit   = 1'b1;
        key_valid = 1'b1;
        @(posedge clk);
        #1;
        key_clear = 1'b0;
        key_valid = 1'b0;
        shiftBits(8'h37, 7, bad);
        checkOutput("clrprio_early", 32'(bad), 32'd0);
        checkOutput("clrprio_not_loaded", 32'(key_loaded), 32'd0);
        shiftBits(8'h80, 1, bad);
        checkOutput("clrprio_loaded", 32'(key_loaded), 32'd1);
        applyStimulus(4'h7, 4'h3, 5'h0B);
        in_valid = 1'b0;
        drainResults();

        // Reset mid-shift drops the partial key
        shiftBits(8'hA5, 5, bad);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rstmid_key_ready", 32'(key_ready), 32'd1);
        checkOutput("rstmid_key_loaded", 32'(key_loaded), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        shiftBits(8'h5A, 7, bad);
        checkOutput("rstmid_early", 32'(bad), 32'd0);
        checkOutput("rstmid_not_loaded", 32'(key_loaded), 32'd0);
        shiftBits(8'h00, 1, bad);
        checkOutput("rstmid_loaded", 32'(key_loaded), 32'd1);
        applyStimulus(4'hA, 4'h5, 5'h0F);
        in_valid = 1'b0;
        drainResults();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
